// File: rtl/wave_capture_pkg.sv
// ============================================================================
// Module      : wave_capture_pkg
// Description : Shared types, widths and sample conversion for wave_capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wave_capture_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DISP_W   = 8;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } cap_state_t;

    // Signed-to-offset conversion of the sample's top byte: flipping the sign
    // bit maps -full-scale to 0, zero to mid-scale and +full-scale to all-ones.
    function automatic logic [DISP_W-1:0] to_offset(input logic [DISP_W-1:0] top_byte);
        return {~top_byte[DISP_W-1], top_byte[DISP_W-2:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wave_capture_zero_cross_detect.sv
// ============================================================================
// Module      : zero_cross_detect
// Description : Remembers the previous accepted sample and pulses trigger on a
//               negative-to-non-negative transition of the sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_cross_detect
    import wave_capture_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                trigger
);

    logic [SAMPLE_W-1:0] prev_sample;
    logic                unused_prev_bits;

    // Track the last accepted sample regardless of capture state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sample <= '0;
        end else if (sample_valid) begin
            prev_sample <= sample_in;
        end
    end

    // Only the sign history matters for crossing detection.
    assign trigger          = sample_valid && prev_sample[SAMPLE_W-1] && !sample_in[SAMPLE_W-1];
    assign unused_prev_bits = ^prev_sample[SAMPLE_W-2:0];

endmodule

`default_nettype wire

// File: rtl/wave_capture.sv
// ============================================================================
// Module      : wave_capture
// Description : Arms on a positive-going zero crossing, captures one frame of
//               2^DEPTH_LOG2 offset-binary samples into the hidden half of a
//               double-buffered RAM, then flips read_index when the display
//               goes idle.
//               Optional build macro WAVE_CAPTURE_DECIM_EN: store only one of
//               every DECIM_FACTOR samples while capturing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DEPTH_LOG2   = 8,
    parameter int DECIM_FACTOR = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    output logic [DEPTH_LOG2:0]   write_address,
    output logic                  write_enable,
    output logic [DISP_W-1:0]     write_sample,
    output logic                  read_index
);

    localparam logic [DEPTH_LOG2-1:0] LAST_INDEX = '1;

    cap_state_t            state;
    cap_state_t            next_state;
    logic [DEPTH_LOG2-1:0] index;
    logic                  trigger;
    logic                  store;
    logic                  keep;
    logic                  flip;

    generate
        if (DECIM_FACTOR < 2) begin : g_decim_check
            $error("wave_capture: DECIM_FACTOR must be >= 2");
        end
    endgenerate

    zero_cross_detect u_zero_cross_detect (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (new_sample_ready),
        .sample_in    (new_sample_in),
        .trigger      (trigger)
    );

`ifdef WAVE_CAPTURE_DECIM_EN
    localparam int CNT_W = $clog2(DECIM_FACTOR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM_FACTOR - 1);

    logic [CNT_W-1:0] decim_cnt;

    // Decimation phase: restarts with each new frame, advances per strobe in ACTIVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decim_cnt <= '0;
        end else if (state == ARMED && trigger) begin
            decim_cnt <= '0;
        end else if (state == ACTIVE && new_sample_ready) begin
            decim_cnt <= (decim_cnt == CNT_LAST) ? '0 : decim_cnt + 1'b1;
        end
    end

    assign keep = (decim_cnt == '0);
`else
    assign keep = 1'b1;
`endif

    // Capture state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARMED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus store/flip strobes.
    always_comb begin
        next_state = state;
        store      = 1'b0;
        flip       = 1'b0;
        case (state)
            ARMED: begin
                if (trigger) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready && keep) begin
                    store = 1'b1;
                    if (index == LAST_INDEX) begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    flip       = 1'b1;
                    next_state = ARMED;
                end
            end
            default: next_state = ARMED;
        endcase
    end

    // Frame write index; wraps to zero naturally after the last store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index <= '0;
        end else if (state == ARMED && trigger) begin
            index <= '0;
        end else if (store) begin
            index <= index + 1'b1;
        end
    end

    // Registered RAM write port, one cycle behind the accepted strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            write_enable <= store;
            if (store) begin
                write_address <= {~read_index, index};
                write_sample  <= to_offset(new_sample_in[SAMPLE_W-1 -: DISP_W]);
            end
        end
    end

    // Buffer swap happens only when leaving WAIT, never mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_index <= 1'b0;
        end else if (flip) begin
            read_index <= ~read_index;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wave_capture.sv
// ============================================================================
// Module      : tb_wave_capture
// Description : Directed self-checking bench for wave_capture. The decimation
//               scenario runs when WAVE_CAPTURE_DECIM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = 16'h0000;
    logic        wave_display_idle = 1'b0;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int tests = 0;
    int fails = 0;

    wave_capture dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of tests");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers; both start and end on a falling edge.
    task automatic do_reset();
        reset = 1'b0;
        new_sample_ready = 1'b0;
        wave_display_idle = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic strobe(input logic [15:0] s);
        new_sample_ready = 1'b1;
        new_sample_in = s;
        @(negedge clk);
        new_sample_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (write_enable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", write_enable); end
        tests++;
        if (write_address !== 9'h000) begin fails++; $display("FAIL reset_addr: got %h expected 000", write_address); end
        tests++;
        if (write_sample !== 8'h00) begin fails++; $display("FAIL reset_sample: got %h expected 00", write_sample); end
        tests++;
        if (read_index !== 1'b0) begin fails++; $display("FAIL reset_ridx: got %b expected 0", read_index); end
        reset = 1'b1;
    endtask

    task automatic test_capture_frame();
        do_reset();
        strobe(16'hFFFB); // -5
        tests++;
        if (write_enable !== 1'b0) begin fails++; $display("FAIL pre_trigger_we: got %b expected 0", write_enable); end
        strobe(16'h0003); // +3 triggers, not stored
        tests++;
        if (write_enable !== 1'b0) begin fails++; $display("FAIL trigger_sample_we: got %b expected 0", write_enable); end
        for (int i = 0; i < 256; i++) begin
            strobe(16'(i));
            tests++;
            if (write_enable !== 1'b1 || write_address !== (9'h100 + 9'(i)) || write_sample !== 8'h80) begin
                fails++;
                $display("FAIL frame1[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=80",
                         i, write_enable, write_address, write_sample, 9'h100 + 9'(i));
            end
        end
        strobe(16'h1234);
        tests++;
        if (write_enable !== 1'b0 || read_index !== 1'b0) begin
            fails++;
            $display("FAIL frame1_wait: got we=%b ridx=%b expected we=0 ridx=0", write_enable, read_index);
        end
    endtask

    task automatic test_wait_and_flip();
        logic [15:0] sine [8] = '{16'h0000, 16'h5A82, 16'h7FFF, 16'h5A82,
                                  16'h0000, 16'hA57E, 16'h8001, 16'hA57E};
        int bad = 0;
        for (int c = 0; c < 1000; c++) begin
            new_sample_ready = (c % 4 == 0);
            new_sample_in = sine[(c / 4) % 8];
            @(negedge clk);
            if (write_enable !== 1'b0 || read_index !== 1'b0) bad++;
        end
        new_sample_ready = 1'b0;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL wait_hold: got %0d bad cycles expected 0", bad); end
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
        tests++;
        if (read_index !== 1'b1) begin fails++; $display("FAIL flip: got ridx=%b expected 1", read_index); end
        strobe(16'hFFFB);
        strobe(16'h0003);
        tests++;
        if (write_enable !== 1'b0) begin fails++; $display("FAIL frame2_trigger_we: got %b expected 0", write_enable); end
        for (int i = 0; i < 256; i++) begin
            strobe(16'(i << 8));
            tests++;
            if (write_enable !== 1'b1 || write_address !== 9'(i) || write_sample !== (8'(i) ^ 8'h80)) begin
                fails++;
                $display("FAIL frame2[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                         i, write_enable, write_address, write_sample, 9'(i), 8'(i) ^ 8'h80);
            end
        end
        strobe(16'h1234);
        tests++;
        if (write_enable !== 1'b0 || read_index !== 1'b1) begin
            fails++;
            $display("FAIL frame2_wait: got we=%b ridx=%b expected we=0 ridx=1", write_enable, read_index);
        end
    endtask

    task automatic test_no_trigger();
        int writes = 0;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            strobe(16'(k * 100));
            if (write_enable !== 1'b0) writes++;
        end
        tests++;
        if (writes != 0) begin fails++; $display("FAIL no_trigger: got %0d writes expected 0", writes); end
    endtask

    task automatic test_mapping();
        logic [15:0] vin [4]  = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
        logic [7:0]  vexp [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        do_reset();
        strobe(16'hFFFF);
        strobe(16'h0001);
        for (int j = 0; j < 4; j++) begin
            strobe(vin[j]);
            tests++;
            if (write_enable !== 1'b1 || write_sample !== vexp[j] || write_address !== (9'h100 + 9'(j))) begin
                fails++;
                $display("FAIL map[%0d]: got we=%b data=%h addr=%h expected we=1 data=%h addr=%h",
                         j, write_enable, write_sample, write_address, vexp[j], 9'h100 + 9'(j));
            end
            @(negedge clk);
            tests++;
            if (write_enable !== 1'b0) begin fails++; $display("FAIL map_gap[%0d]: got we=%b expected 0", j, write_enable); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int writes = 0;
        do_reset();
        strobe(16'hFFFF);
        strobe(16'h0001);
        for (int i = 0; i < 256; i++) strobe(16'h0000);
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
        tests++;
        if (read_index !== 1'b1) begin fails++; $display("FAIL mid_flip: got ridx=%b expected 1", read_index); end
        strobe(16'hFFFF);
        strobe(16'h0001);
        for (int i = 0; i < 100; i++) begin
            strobe(16'h0000);
            if (write_enable === 1'b1) writes++;
        end
        tests++;
        if (writes != 100) begin fails++; $display("FAIL mid_writes: got %0d expected 100", writes); end
        #1 reset = 1'b0;
        #1;
        tests++;
        if (write_enable !== 1'b0 || write_address !== 9'h000 || write_sample !== 8'h00 || read_index !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got we=%b addr=%h data=%h ridx=%b expected all zero",
                     write_enable, write_address, write_sample, read_index);
        end
        @(negedge clk);
        reset = 1'b1;
        writes = 0;
        for (int k = 1; k <= 10; k++) begin
            strobe(16'(k * 300));
            if (write_enable !== 1'b0) writes++;
        end
        tests++;
        if (writes != 0) begin fails++; $display("FAIL post_reset_quiet: got %0d writes expected 0", writes); end
        strobe(16'hFFFF);
        strobe(16'h0001);
        strobe(16'h0100);
        tests++;
        if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h81) begin
            fails++;
            $display("FAIL post_reset_capture: got we=%b addr=%h data=%h expected we=1 addr=100 data=81",
                     write_enable, write_address, write_sample);
        end
    endtask

`ifdef WAVE_CAPTURE_DECIM_EN
    task automatic test_decim();
        int writes = 0;
        do_reset();
        strobe(16'hFFFF);
        strobe(16'h0001);
        for (int i = 0; i < 512; i++) begin
            strobe(16'(i * 128));
            if (write_enable === 1'b1) writes++;
            tests++;
            if (i % 2 == 0) begin
                if (write_enable !== 1'b1 || write_address !== (9'h100 + 9'(i / 2)) || write_sample !== (8'(i / 2) ^ 8'h80)) begin
                    fails++;
                    $display("FAIL decim[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                             i, write_enable, write_address, write_sample, 9'h100 + 9'(i / 2), 8'(i / 2) ^ 8'h80);
                end
            end else begin
                if (write_enable !== 1'b0) begin fails++; $display("FAIL decim_skip[%0d]: got we=%b expected 0", i, write_enable); end
            end
        end
        tests++;
        if (writes != 256) begin fails++; $display("FAIL decim_count: got %0d expected 256", writes); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef WAVE_CAPTURE_DECIM_EN
        test_no_trigger();
        test_decim();
`else
        test_capture_frame();
        test_wait_and_flip();
        test_no_trigger();
        test_mapping();
        test_reset_mid_frame();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
